// File: rtl/button_conditioner.sv
// Two-channel push-button front end: 2-FF synchroniser, debounce and
// hold-time lockout per channel. Registered level, press strobe and stuck
// flag per button.

module button_conditioner_ch #(
    parameter int DB_CYCLES  = 4,
    parameter int CNT_W      = 8,
    parameter int HOLD_LIMIT = 50000,
    parameter int HOLD_W     = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic stuck_o
);
    typedef enum logic [2:0] {REL, PRESS_CHK, HELD, REL_CHK, STUCK} state_t;

    localparam logic [CNT_W-1:0]  DB_MAX   = CNT_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'((HOLD_LIMIT == 0) ? 0 : HOLD_LIMIT - 1);
    localparam bit                HOLD_EN  = (HOLD_LIMIT != 0);

    logic [1:0]        sync_q;
    logic              s;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              stuck_q, stuck_d;

    assign s = sync_q[1];

    // Synchroniser, FSM state, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            state_q <= REL;
            cnt_q   <= '0;
            hold_q  <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            stuck_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            level_q <= level_d;
            press_q <= press_d;
            stuck_q <= stuck_d;
        end
    end

    // Next state: any contrary sample restarts the debounce check
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        case (state_q)
            REL: begin
                if (s) begin
                    state_d = PRESS_CHK;
                    cnt_d   = CNT_W'(1);
                end
            end
            PRESS_CHK: begin
                if (!s) begin
                    state_d = REL;
                    cnt_d   = '0;
                end else if (cnt_q == DB_MAX) begin
                    state_d = HELD;
                    hold_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!s) begin
                    state_d = REL_CHK;
                    cnt_d   = CNT_W'(1);
                end else if (HOLD_EN && hold_q == HOLD_MAX) begin
                    state_d = STUCK;
                    cnt_d   = '0;
                end else if (HOLD_EN) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            REL_CHK: begin
                // hold stays frozen; a bounce back to high keeps the elapsed allowance
                if (s) begin
                    state_d = HELD;
                end else if (cnt_q == DB_MAX) begin
                    state_d = REL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STUCK: begin
                if (s) begin
                    cnt_d = '0;
                end else if (cnt_q == DB_MAX) begin
                    state_d = REL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = REL;
                cnt_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    // Outputs decoded from the next state so they land registered with it
    always_comb begin
        level_d = (state_d == HELD) || (state_d == REL_CHK);
        press_d = (state_q == PRESS_CHK) && (state_d == HELD);
        stuck_d = (state_d == STUCK);
    end

    assign level_o = level_q;
    assign press_o = press_q;
    assign stuck_o = stuck_q;
endmodule

module button_conditioner #(
    parameter int DB_CYCLES  = 4,
    parameter int CNT_W      = 8,
    parameter int HOLD_LIMIT = 50000,
    parameter int HOLD_W     = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pbl_raw,
    input  logic pbr_raw,
    output logic pbl,
    output logic pbr,
    output logic pbl_press,
    output logic pbr_press,
    output logic pbl_stuck,
    output logic pbr_stuck
);
    localparam int NUM_LANES = 2;   // lane 0 = left, lane 1 = right

    logic [NUM_LANES-1:0] raw, lvl, prs, stk;

    assign raw = {pbr_raw, pbl_raw};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_ch
        button_conditioner_ch #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W),
            .HOLD_LIMIT(HOLD_LIMIT),
            .HOLD_W    (HOLD_W)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .raw_i  (raw[g]),
            .level_o(lvl[g]),
            .press_o(prs[g]),
            .stuck_o(stk[g])
        );
    end

    assign pbl       = lvl[0];
    assign pbr       = lvl[1];
    assign pbl_press = prs[0];
    assign pbr_press = prs[1];
    assign pbl_stuck = stk[0];
    assign pbr_stuck = stk[1];
endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios with hand-derived edge
// counts plus randomized bouncing pins checked every cycle against a
// run-length model of the debounce/lockout rules.

module tb_button_conditioner;
    localparam int DB   = 4;
    localparam int HOLD = 20;
    localparam int LAT  = DB + 1;   // edge index (from e0) where level/press rise

    logic clk, rst, pbl_raw, pbr_raw;
    logic pbl, pbr, pbl_press, pbr_press, pbl_stuck, pbr_stuck;

    int n_chk, n_fail;

    // model: two-stage pin delay, accepted level, lockout flag, run length
    // of samples disagreeing with the accepted state, high samples held
    bit mq0[2], mq1[2], mlvl[2], mstk[2], mprs[2];
    int mrun[2], mheld[2];

    button_conditioner #(
        .DB_CYCLES(DB), .CNT_W(8), .HOLD_LIMIT(HOLD), .HOLD_W(16)
    ) dut (
        .clk(clk), .rst(rst), .pbl_raw(pbl_raw), .pbr_raw(pbr_raw),
        .pbl(pbl), .pbr(pbr), .pbl_press(pbl_press), .pbr_press(pbr_press),
        .pbl_stuck(pbl_stuck), .pbr_stuck(pbr_stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            mq0[c] = 0; mq1[c] = 0; mlvl[c] = 0; mstk[c] = 0; mprs[c] = 0;
            mrun[c] = 0; mheld[c] = 0;
        end
    endtask

    task automatic model_step(input bit l, input bit r);
        bit s;
        for (int c = 0; c < 2; c++) begin
            s       = mq1[c];
            mq1[c]  = mq0[c];
            mq0[c]  = (c == 0) ? l : r;
            mprs[c] = 0;
            if (mstk[c]) begin
                mrun[c] = s ? 0 : mrun[c] + 1;
                if (mrun[c] == DB) begin mstk[c] = 0; mrun[c] = 0; end
            end else if (!mlvl[c]) begin
                mrun[c] = s ? mrun[c] + 1 : 0;
                if (mrun[c] == DB) begin
                    mlvl[c] = 1; mprs[c] = 1; mheld[c] = 0; mrun[c] = 0;
                end
            end else if (!s) begin
                mrun[c]++;
                if (mrun[c] == DB) begin mlvl[c] = 0; mrun[c] = 0; end
            end else if (mrun[c] > 0) begin
                mrun[c] = 0;            // bounce back to high, allowance not reset
            end else if (HOLD != 0) begin
                mheld[c]++;
                if (mheld[c] == HOLD) begin mlvl[c] = 0; mstk[c] = 1; end
            end
        end
    endtask

    // one clock: drive pins (called at negedge), compare after the edge
    task automatic step(input bit l, input bit r);
        pbl_raw = l;
        pbr_raw = r;
        @(posedge clk);
        model_step(l, r);
        #1;
        chk("model", {pbl, pbr, pbl_press, pbr_press, pbl_stuck, pbr_stuck},
            {mlvl[0], mlvl[1], mprs[0], mprs[1], mstk[0], mstk[1]});
        @(negedge clk);
    endtask

    // async reset: outputs must clear with no clock edge
    task automatic rst_pulse();
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_async", {pbl, pbr, pbl_press, pbr_press, pbl_stuck, pbr_stuck}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bit lv[2];
        int left[2];
        n_chk = 0; n_fail = 0;
        rst = 1'b1; pbl_raw = 1'b0; pbr_raw = 1'b0;
        model_reset();
        #2;
        rst_pulse();

        // clean press held into lockout, then release and re-press
        for (int k = 0; k < 40; k++) begin
            step(1, 0);
            chk("press_lat", pbl_press, int'(k == LAT));
            chk("lock_lvl", pbl, int'(k >= LAT && k < LAT + HOLD));
            chk("lock_stuck", pbl_stuck, int'(k >= LAT + HOLD));
            chk("pbr_quiet", {pbr, pbr_press}, 0);
        end
        for (int j = 0; j < 10; j++) begin
            step(0, 0);
            chk("stuck_clr", pbl_stuck, int'(j < LAT));
        end
        for (int j = 0; j < 8; j++) begin
            step(1, 0);
            chk("repress", pbl_press, int'(j == LAT));
        end
        for (int j = 0; j < 8; j++) step(0, 0);

        // release glitch: 2-cycle drop keeps level, later 4-cycle low releases
        for (int k = 0; k < 25; k++) begin
            step(!(k == 8 || k == 9 || k >= 14), 0);
            chk("glitch_prs", pbl_press, int'(k == LAT));
            chk("glitch_lvl", pbl, int'(k >= LAT && k < 14 + LAT));
        end

        // press bounce: 3 high, 1 low, 10 high
        for (int k = 0; k < 14; k++) begin
            step(k != 3, 0);
            chk("bounce_prs", pbl_press, int'(k == 4 + LAT));
            chk("bounce_lvl", pbl, int'(k >= 4 + LAT));
        end
        for (int j = 0; j < 8; j++) step(0, 0);

        // simultaneous press, reset while held, re-press after reset
        for (int k = 0; k < 9; k++) begin
            step(1, 1);
            chk("sim_prs", {pbl_press, pbr_press}, (k == LAT) ? 3 : 0);
        end
        chk("sim_held", {pbl, pbr}, 3);
        rst_pulse();
        for (int k = 0; k < 7; k++) begin
            step(1, 1);
            chk("rst_repress", {pbl_press, pbr_press}, (k == LAT) ? 3 : 0);
        end
        for (int j = 0; j < 8; j++) step(0, 0);

        // randomized bouncing, long holds and occasional resets
        lv[0] = 0; lv[1] = 0; left[0] = 0; left[1] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 2; c++) begin
                if (left[c] == 0) begin
                    lv[c]   = !lv[c];
                    left[c] = ($urandom_range(0, 4) == 0) ? $urandom_range(18, 40)
                                                          : $urandom_range(1, 7);
                end
                left[c]--;
            end
            if ($urandom_range(0, 499) == 0) rst_pulse();
            else step(lv[0], lv[1]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
